time_keeper: RTL and testbench

- Real-time hours/minutes/seconds counter for the Numitron clock.
- Sits directly upstream of the binary-to-BCD stage; each 7-bit binary output feeds one BCD converter, then the tube drivers.
- Derives a 1 Hz tick from the system clock.
- Provides a two-button set mode (mode / increment) for hours and minutes.

---
 rtl/time_keeper_pkg.sv | 24 ++
 rtl/time_keeper_tick_prescaler.sv | 38 +++
 rtl/time_keeper.sv | 114 +++++++++++
 tb/tb_time_keeper.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/time_keeper_pkg.sv
// Shared limits, FSM state type and wrap-around helpers for the time_keeper clock core.
// Used by both the default 24-hour build and the TIME_KEEPER_12H_EN build.
package time_keeper_pkg;

  localparam logic [5:0] SEC_MAX = 6'd59;
  localparam logic [5:0] MIN_MAX = 6'd59;
  localparam logic [4:0] HR_MAX  = 5'd23;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SET_HR  = 2'd1,
    SET_MIN = 2'd2
  } state_e;

  // Anything at or past the limit returns to zero, so an illegal value also clears.
  function automatic logic [5:0] wrapInc6(input logic [5:0] value, input logic [5:0] limit);
    return (value >= limit) ? 6'd0 : value + 6'd1;
  endfunction

  function automatic logic [4:0] wrapInc5(input logic [4:0] value, input logic [4:0] limit);
    return (value >= limit) ? 5'd0 : value + 5'd1;
  endfunction

endpackage

// File: rtl/time_keeper_tick_prescaler.sv
// Divides the system clock down to a one-cycle 1 Hz pulse.
// 'wrap' is the combinational terminal-count flag; 'tick' is its registered copy.
module tick_prescaler #(
  parameter int CLK_HZ  = 50000000,
  parameter int PRESC_W = 26
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick,
  output logic wrap
);

  localparam logic [PRESC_W-1:0] TERM = PRESC_W'(CLK_HZ - 1);

  logic [PRESC_W-1:0] presc_q, presc_d;
  logic               tick_q;

  assign wrap = (presc_q == TERM);
  assign tick = tick_q;

  // Clearing restarts a full second, so the next tick lands CLK_HZ cycles later.
  always_comb begin
    presc_d = presc_q + PRESC_W'(1);
    if (clr || wrap) presc_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      tick_q  <= wrap;
    end
  end

endmodule

// File: rtl/time_keeper.sv
// Hours/minutes/seconds counter with a two-button set mode for the Numitron clock.
// Define TIME_KEEPER_12H_EN for 12-hour display with an afternoon flag.
module time_keeper
  import time_keeper_pkg::*;
#(
  parameter int CLK_HZ  = 50000000,
  parameter int PRESC_W = 26
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [6:0] seconds,
  output logic [6:0] minutes,
  output logic [6:0] hours,
  output logic       pm,
  output logic       set_hr,
  output logic       set_min,
  output logic       tick_1hz
);

  state_e     state_q, state_d;
  logic [5:0] sec_q, sec_d;
  logic [5:0] min_q, min_d;
  logic [4:0] hr_q, hr_d;
  logic       btnMode_q, btnInc_q;
  logic       modeEdge, incEdge;
  logic       secTick, clrPresc;

  tick_prescaler #(
    .CLK_HZ (CLK_HZ),
    .PRESC_W(PRESC_W)
  ) u_prescaler (
    .clk (clk),
    .rst (rst),
    .clr (clrPresc),
    .tick(tick_1hz),
    .wrap(secTick)
  );

  assign modeEdge = btn_mode & ~btnMode_q;
  assign incEdge  = btn_inc & ~btnInc_q;

  always_comb begin
    state_d  = state_q;
    sec_d    = sec_q;
    min_d    = min_q;
    hr_d     = hr_q;
    clrPresc = 1'b0;
    unique case (state_q)
      RUN: begin
        if (secTick) begin
          sec_d = wrapInc6(sec_q, SEC_MAX);
          if (sec_q >= SEC_MAX) begin
            min_d = wrapInc6(min_q, MIN_MAX);
            if (min_q >= MIN_MAX) hr_d = wrapInc5(hr_q, HR_MAX);
          end
        end
        if (modeEdge) state_d = SET_HR;
      end
      SET_HR: begin
        if (incEdge) hr_d = wrapInc5(hr_q, HR_MAX);
        if (modeEdge) state_d = SET_MIN;
      end
      SET_MIN: begin
        if (incEdge) min_d = wrapInc6(min_q, MIN_MAX);
        // Restart the second on exit so the first tick is a whole second away.
        if (modeEdge) begin
          state_d  = RUN;
          sec_d    = 6'd0;
          clrPresc = 1'b1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // History resets high so a button held through reset release gives no edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RUN;
      sec_q     <= 6'd0;
      min_q     <= 6'd0;
      hr_q      <= 5'd0;
      btnMode_q <= 1'b1;
      btnInc_q  <= 1'b1;
    end else begin
      state_q   <= state_d;
      sec_q     <= sec_d;
      min_q     <= min_d;
      hr_q      <= hr_d;
      btnMode_q <= btn_mode;
      btnInc_q  <= btn_inc;
    end
  end

  assign seconds = {1'b0, sec_q};
  assign minutes = {1'b0, min_q};
  assign set_hr  = (state_q == SET_HR);
  assign set_min = (state_q == SET_MIN);

`ifdef TIME_KEEPER_12H_EN
  always_comb begin
    hours = {2'b00, hr_q};
    if (hr_q == 5'd0)       hours = 7'd12;
    else if (hr_q > 5'd12)  hours = {2'b00, hr_q - 5'd12};
  end
  assign pm = (hr_q >= 5'd12);
`else
  assign hours = {2'b00, hr_q};
  assign pm    = 1'b0;
`endif

endmodule

// File: tb/tb_time_keeper.sv
// Directed self-checking bench for time_keeper with a 4 Hz "system clock".
// Hour/pm expectations follow TIME_KEEPER_12H_EN when it is defined.
module tb_time_keeper;

  localparam int CLK_HZ  = 4;
  localparam int PRESC_W = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btnMode = 1'b0;
  logic       btnInc = 1'b0;
  logic [6:0] seconds, minutes, hours;
  logic       pm, setHr, setMin, tick1hz;

  int checkCount = 0;
  int passCount  = 0;

  time_keeper #(
    .CLK_HZ (CLK_HZ),
    .PRESC_W(PRESC_W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .btn_mode(btnMode),
    .btn_inc (btnInc),
    .seconds (seconds),
    .minutes (minutes),
    .hours   (hours),
    .pm      (pm),
    .set_hr  (setHr),
    .set_min (setMin),
    .tick_1hz(tick1hz)
  );

  always #5 clk = ~clk;

  // Counts every comparison and reports the ones that disagree.
  task automatic checkOutput(input string tag, input int actual, input int expected);
    checkCount++;
    if (actual == expected) passCount++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
  endtask

  // Drives the buttons, then advances to the falling edge after 'cycles' rising edges.
  task automatic applyStimulus(input logic mode, input logic inc, input int cycles);
    btnMode = mode;
    btnInc  = inc;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic pressMode();
    applyStimulus(1'b1, 1'b0, 1);
    applyStimulus(1'b0, 1'b0, 1);
  endtask

  task automatic pressInc(input int n);
    repeat (n) begin
      applyStimulus(1'b0, 1'b1, 1);
      applyStimulus(1'b0, 1'b0, 1);
    end
  endtask

  // Displayed hour for an internal 0..23 hour.
  function automatic int expHours(input int h);
`ifdef TIME_KEEPER_12H_EN
    if (h == 0) return 12;
    if (h > 12) return h - 12;
    return h;
`else
    return h;
`endif
  endfunction

  function automatic int expPm(input int h);
`ifdef TIME_KEEPER_12H_EN
    return (h >= 12) ? 1 : 0;
`else
    return (h < 0) ? 1 : 0;
`endif
  endfunction

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int ticksSeen;
    int badSpacing;
    int waitCycles;

    // Reset state while rst is still high.
    applyStimulus(1'b0, 1'b0, 3);
    checkOutput("reset_seconds", seconds, 0);
    checkOutput("reset_minutes", minutes, 0);
    checkOutput("reset_hours", hours, expHours(0));
    checkOutput("reset_pm", pm, expPm(0));
    checkOutput("reset_set_hr", setHr, 0);
    checkOutput("reset_set_min", setMin, 0);
    checkOutput("reset_tick", tick1hz, 0);
    rst = 1'b0;

    // Free run: one tick every fourth cycle, ten seconds in forty cycles.
    ticksSeen  = 0;
    badSpacing = 0;
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1'b0, 1'b0, 1);
      if (tick1hz != ((i % 4) == 3)) badSpacing++;
      ticksSeen += int'(tick1hz);
    end
    checkOutput("run_tick_count", ticksSeen, 10);
    checkOutput("run_tick_spacing_errors", badSpacing, 0);
    checkOutput("run_seconds", seconds, 10);
    checkOutput("run_minutes", minutes, 0);
    checkOutput("run_hours", hours, expHours(0));

    // Preload 23:59 through set mode.
    pressMode();
    checkOutput("enter_set_hr", setHr, 1);
    pressInc(23);
    checkOutput("preload_hours", hours, expHours(23));
    checkOutput("set_hr_frozen_seconds", seconds, 10);
    pressMode();
    checkOutput("enter_set_min", setMin, 1);
    pressInc(59);
    checkOutput("preload_minutes", minutes, 59);

    // Leave set mode and time the first tick from the exit edge.
    applyStimulus(1'b1, 1'b0, 1);
    checkOutput("exit_seconds_cleared", seconds, 0);
    checkOutput("exit_set_min", setMin, 0);
    btnMode = 1'b0;
    waitCycles = 0;
    do begin
      applyStimulus(1'b0, 1'b0, 1);
      waitCycles++;
    end while (!tick1hz && waitCycles < 10);
    checkOutput("first_tick_latency", waitCycles, CLK_HZ);
    checkOutput("first_tick_seconds", seconds, 1);

    // Run to 23:59:59, then the full cascade on the next tick.
    applyStimulus(1'b0, 1'b0, 58 * CLK_HZ);
    checkOutput("pre_wrap_seconds", seconds, 59);
    checkOutput("pre_wrap_minutes", minutes, 59);
    checkOutput("pre_wrap_hours", hours, expHours(23));
    checkOutput("pre_wrap_pm", pm, expPm(23));
    applyStimulus(1'b0, 1'b0, CLK_HZ);
    checkOutput("wrap_seconds", seconds, 0);
    checkOutput("wrap_minutes", minutes, 0);
    checkOutput("wrap_hours", hours, expHours(0));
    checkOutput("wrap_pm", pm, expPm(0));

    // Hour wrap 23->0 while setting, with no carry into minutes.
    pressMode();
    pressInc(25);
    checkOutput("set_hr_wrap_hours", hours, expHours(1));
    checkOutput("set_hr_wrap_minutes", minutes, 0);
    pressMode();
    pressInc(61);
    checkOutput("set_min_wrap_minutes", minutes, 1);
    checkOutput("set_min_wrap_hours", hours, expHours(1));

    // A held increment button counts once.
    applyStimulus(1'b0, 1'b1, 20);
    applyStimulus(1'b0, 1'b0, 1);
    checkOutput("held_inc_minutes", minutes, 2);

    // Increments in RUN are ignored.
    pressMode();
    checkOutput("back_to_run_seconds", seconds, 0);
    pressInc(3);
    checkOutput("run_inc_minutes", minutes, 2);
    checkOutput("run_inc_hours", hours, expHours(1));

    // Mode held through reset release must not enter set mode.
    rst = 1'b1;
    applyStimulus(1'b1, 1'b0, 3);
    rst = 1'b0;
    applyStimulus(1'b1, 1'b0, 4);
    checkOutput("held_mode_set_hr", setHr, 0);
    checkOutput("held_mode_set_min", setMin, 0);
    applyStimulus(1'b0, 1'b0, 1);

    // Reset from SET_HR at 05:30.
    pressMode();
    pressInc(5);
    pressMode();
    pressInc(30);
    pressMode();
    pressMode();
    checkOutput("pre_reset_set_hr", setHr, 1);
    checkOutput("pre_reset_hours", hours, expHours(5));
    checkOutput("pre_reset_minutes", minutes, 30);
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1);
    checkOutput("abort_seconds", seconds, 0);
    checkOutput("abort_minutes", minutes, 0);
    checkOutput("abort_hours", hours, expHours(0));
    checkOutput("abort_set_hr", setHr, 0);
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 1);

    // Hour display decode at noon, 13:00 and 00:30.
    pressMode();
    pressInc(12);
    checkOutput("noon_hours", hours, expHours(12));
    checkOutput("noon_pm", pm, expPm(12));
    pressInc(1);
    checkOutput("h13_hours", hours, expHours(13));
    checkOutput("h13_pm", pm, expPm(13));
    pressInc(11);
    pressMode();
    pressInc(30);
    checkOutput("h0030_minutes", minutes, 30);
    checkOutput("h0030_hours", hours, expHours(0));
    checkOutput("h0030_pm", pm, expPm(0));

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
